// File: rtl/nios2_debug_jtag_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: runs UIR/CDR/SDR/UDR/RTI on a divided TCK.
// Optional macro NIOS2_DBG_SCAN_IR_CAPTURE_EN captures ir_out at the end of UIR and returns it as rsp_ir.
module nios2_debug_jtag_scan_master #(
   parameter int SR_WIDTH   = 38,
   parameter int TCK_DIV    = 2,
   parameter int RTI_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_ir,
   input  logic [SR_WIDTH-1:0] cmd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [SR_WIDTH-1:0] rsp_data,
   output logic [1:0]          rsp_ir,
   output logic                vs_tck,
   output logic                vs_tdi,
   input  logic                vs_tdo,
   output logic [1:0]          ir_in,
   input  logic [1:0]          ir_out,
   output logic                vs_uir,
   output logic                vs_cdr,
   output logic                vs_sdr,
   output logic                vs_udr,
   output logic                vs_rti
);
   typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE} state_t;

   localparam int DIV_W   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam int CNT_MAX = (SR_WIDTH > RTI_CYCLES) ? SR_WIDTH : RTI_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
   localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(SR_WIDTH - 1);
   localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES - 1);

   state_t              r_state;
   logic [DIV_W-1:0]    r_div;
   logic [CNT_W-1:0]    r_cnt;
   logic [SR_WIDTH-1:0] r_shreg;
   logic [SR_WIDTH-1:0] r_rsp_data;
   logic [1:0]          r_ir_in;
   logic                r_cmd_ready, r_rsp_valid, r_tck, r_tdi;
   logic                r_uir, r_cdr, r_sdr, r_udr, r_rti;

   logic                w_busy, w_wrap, w_fall, w_accept, w_rsp_hs;
   logic [SR_WIDTH-1:0] w_shreg_nxt;

`ifdef NIOS2_DBG_SCAN_IR_CAPTURE_EN
   logic [1:0] r_ir_cap;
   logic [1:0] r_rsp_ir;
   assign rsp_ir = r_rsp_ir;
`else
   logic w_unused_ir;
   assign w_unused_ir = ^ir_out;
   assign rsp_ir      = 2'b00;
`endif

   // Every state change and the TDO capture happen on the clk edge that ends the TCK high phase.
   assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_wrap      = w_busy && (r_div == DIV_LAST);
   assign w_fall      = w_wrap && r_tck;
   assign w_accept    = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
   assign w_rsp_hs    = r_rsp_valid && rsp_ready;
   assign w_shreg_nxt = {vs_tdo, r_shreg[SR_WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_div       <= '0;
         r_tck       <= 1'b0;
         r_tdi       <= 1'b0;
         r_ir_in     <= 2'b00;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_uir       <= 1'b0;
         r_cdr       <= 1'b0;
         r_sdr       <= 1'b0;
         r_udr       <= 1'b0;
         r_rti       <= 1'b0;
`ifdef NIOS2_DBG_SCAN_IR_CAPTURE_EN
         r_rsp_ir    <= 2'b00;
`endif
      end else begin
         if (w_busy) begin
            r_div <= w_wrap ? '0 : r_div + 1'b1;
            if (w_wrap) r_tck <= ~r_tck;
         end
         if (w_rsp_hs) r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ir_in     <= cmd_ir;
                  r_shreg     <= cmd_data;
                  r_div       <= '0;
                  r_tck       <= 1'b0;
                  r_tdi       <= 1'b0;
                  r_uir       <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  r_state     <= S_UIR;
               end else begin
                  r_cmd_ready <= !r_rsp_valid || rsp_ready;
               end
            end
            S_UIR: if (w_fall) begin
               r_uir   <= 1'b0;
               r_cdr   <= 1'b1;
`ifdef NIOS2_DBG_SCAN_IR_CAPTURE_EN
               r_ir_cap <= ir_out;
`endif
               r_state <= S_CDR;
            end
            S_CDR: if (w_fall) begin
               r_cdr   <= 1'b0;
               r_sdr   <= 1'b1;
               r_tdi   <= r_shreg[0];
               r_cnt   <= '0;
               r_state <= S_SDR;
            end
            S_SDR: if (w_fall) begin
               r_shreg <= w_shreg_nxt;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == SDR_LAST) begin
                  r_sdr   <= 1'b0;
                  r_udr   <= 1'b1;
                  r_tdi   <= 1'b0;
                  r_state <= S_UDR;
               end else begin
                  r_tdi <= w_shreg_nxt[0];
               end
            end
            S_UDR: if (w_fall) begin
               r_udr   <= 1'b0;
               r_rti   <= 1'b1;
               r_cnt   <= '0;
               r_state <= S_RTI;
            end
            S_RTI: if (w_fall) begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == RTI_LAST) begin
                  r_rti       <= 1'b0;
                  r_rsp_data  <= r_shreg;
                  r_rsp_valid <= 1'b1;
`ifdef NIOS2_DBG_SCAN_IR_CAPTURE_EN
                  r_rsp_ir    <= r_ir_cap;
`endif
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_cmd_ready <= w_rsp_hs;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign vs_tck    = r_tck;
   assign vs_tdi    = r_tdi;
   assign ir_in     = r_ir_in;
   assign vs_uir    = r_uir;
   assign vs_cdr    = r_cdr;
   assign vs_sdr    = r_sdr;
   assign vs_udr    = r_udr;
   assign vs_rti    = r_rti;
endmodule

// File: tb/tb_nios2_debug_jtag_scan_master.sv
// Bench for nios2_debug_jtag_scan_master: default instance (TCK_DIV=2, RTI=4) and fast instance (TCK_DIV=1, RTI=1).
module tb_nios2_debug_jtag_scan_master;
   localparam int W = 38;
   localparam logic [1:0] IR_STAT = 2'b10;
`ifdef NIOS2_DBG_SCAN_IR_CAPTURE_EN
   localparam logic [1:0] EXP_RSP_IR = 2'b10;
`else
   localparam logic [1:0] EXP_RSP_IR = 2'b00;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic         cmd_valid_a [2];
   logic         cmd_ready_a [2];
   logic [1:0]   cmd_ir_a    [2];
   logic [W-1:0] cmd_data_a  [2];
   logic         rsp_valid_a [2];
   logic         rsp_ready_a [2];
   logic [W-1:0] rsp_data_a  [2];
   logic [1:0]   rsp_ir_a    [2];
   logic         vs_tck_a    [2];
   logic         vs_tdi_a    [2];
   logic         tdo_a       [2];
   logic [1:0]   ir_in_a     [2];
   logic [1:0]   ir_out_a    [2];
   logic         vs_uir_a    [2];
   logic         vs_cdr_a    [2];
   logic         vs_sdr_a    [2];
   logic         vs_udr_a    [2];
   logic         vs_rti_a    [2];

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int DIV = (k == 0) ? 2 : 1;
      localparam int RTI = (k == 0) ? 4 : 1;
      nios2_debug_jtag_scan_master #(.SR_WIDTH(W), .TCK_DIV(DIV), .RTI_CYCLES(RTI)) u_dut (
         .clk(clk), .reset(reset),
         .cmd_valid(cmd_valid_a[k]), .cmd_ready(cmd_ready_a[k]),
         .cmd_ir(cmd_ir_a[k]), .cmd_data(cmd_data_a[k]),
         .rsp_valid(rsp_valid_a[k]), .rsp_ready(rsp_ready_a[k]),
         .rsp_data(rsp_data_a[k]), .rsp_ir(rsp_ir_a[k]),
         .vs_tck(vs_tck_a[k]), .vs_tdi(vs_tdi_a[k]), .vs_tdo(tdo_a[k]),
         .ir_in(ir_in_a[k]), .ir_out(ir_out_a[k]),
         .vs_uir(vs_uir_a[k]), .vs_cdr(vs_cdr_a[k]), .vs_sdr(vs_sdr_a[k]),
         .vs_udr(vs_udr_a[k]), .vs_rti(vs_rti_a[k])
      );
      assign ir_out_a[k] = vs_uir_a[k] ? IR_STAT : 2'b00;
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int div_of(input int k); return (k == 0) ? 2 : 1; endfunction
   function automatic int rti_of(input int k); return (k == 0) ? 4 : 1; endfunction
   function automatic int lat_of(input int k); return (3 + W + rti_of(k)) * 2 * div_of(k); endfunction

   // Slave: reloads its capture value while UIR is shown, shifts on rising TCK under SDR,
   // and holds TDO steady through the high phase.
   logic [W-1:0] preload_val [2];
   logic [W-1:0] slave_sr    [2];
   logic         tck_prev    [2] = '{1'b0, 1'b0};
   int           tck_rises   [2] = '{0, 0};
   int           sdr_rises   [2] = '{0, 0};
   initial begin tdo_a[0] = 1'b0; tdo_a[1] = 1'b0; end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (vs_uir_a[k] === 1'b1) slave_sr[k] = preload_val[k];
         if (vs_tck_a[k] === 1'b1 && tck_prev[k] === 1'b0) begin
            tck_rises[k]++;
            if (vs_sdr_a[k] === 1'b1) begin
               sdr_rises[k]++;
               tdo_a[k]    = slave_sr[k][0];
               slave_sr[k] = {vs_tdi_a[k], slave_sr[k][W-1:1]};
            end
         end
         tck_prev[k] = vs_tck_a[k];
      end
   end

   // Transaction-level model: time since accept decides every indicator.
   bit           m_busy  [2] = '{1'b0, 1'b0};
   bit           m_pend  [2] = '{1'b0, 1'b0};
   int           m_t     [2] = '{0, 0};
   logic [1:0]   m_ir    [2] = '{2'b00, 2'b00};
   logic [W-1:0] m_data  [2];
   logic [W-1:0] m_snap  [2];
   logic [W-1:0] m_rsp   [2] = '{'0, '0};
   logic [1:0]   m_rspir [2] = '{2'b00, 2'b00};

   always @(posedge clk) begin
      bit acc;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_busy[k] = 1'b0; m_pend[k] = 1'b0; m_t[k] = 0; m_ir[k] = 2'b00;
            m_rsp[k] = '0; m_rspir[k] = 2'b00;
         end else begin
            acc = !m_busy[k] && !m_pend[k] && (cmd_valid_a[k] === 1'b1);
            if (m_pend[k] && rsp_ready_a[k] === 1'b1) m_pend[k] = 1'b0;
            if (m_busy[k]) begin
               m_t[k]++;
               if (m_t[k] == lat_of(k)) begin
                  m_busy[k]  = 1'b0;
                  m_pend[k]  = 1'b1;
                  m_rsp[k]   = m_snap[k];
                  m_rspir[k] = EXP_RSP_IR;
                  chk($sformatf("slave_end%0d", k), slave_sr[k], m_data[k]);
               end
            end
            if (acc) begin
               m_busy[k] = 1'b1; m_t[k] = 0; m_ir[k] = cmd_ir_a[k];
               m_data[k] = cmd_data_a[k]; m_snap[k] = preload_val[k];
            end
         end
      end
   end

   function automatic logic [12:0] model_ctl(input int k);
      logic tck, uir, cdr, sdr, udr, rti, tdi;
      int p, ph;
      {tck, uir, cdr, sdr, udr, rti, tdi} = '0;
      if (m_busy[k]) begin
         p   = m_t[k] / (2 * div_of(k));
         ph  = m_t[k] % (2 * div_of(k));
         tck = (ph >= div_of(k));
         uir = (p == 0);
         cdr = (p == 1);
         sdr = (p >= 2) && (p < 2 + W);
         udr = (p == 2 + W);
         rti = (p > 2 + W);
         if (sdr) tdi = m_data[k][p-2];
      end
      return {tck, uir, cdr, sdr, udr, rti, tdi, m_ir[k],
              !m_busy[k] && !m_pend[k], m_pend[k], m_rspir[k]};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("ctl%0d", k),
                {vs_tck_a[k], vs_uir_a[k], vs_cdr_a[k], vs_sdr_a[k], vs_udr_a[k], vs_rti_a[k],
                 vs_tdi_a[k], ir_in_a[k], cmd_ready_a[k], rsp_valid_a[k], rsp_ir_a[k]},
                model_ctl(k));
            chk($sformatf("rsp_data%0d", k), rsp_data_a[k], m_rsp[k]);
         end
      end
   end

   task automatic do_scan(input int k, input logic [1:0] ir, input logic [W-1:0] data,
                          input logic [W-1:0] pre, output int lat);
      int t0, n, s0;
      preload_val[k] = pre;
      cmd_ir_a[k]    = ir;
      cmd_data_a[k]  = data;
      cmd_valid_a[k] = 1'b1;
      s0 = sdr_rises[k];
      @(negedge clk);
      cmd_valid_a[k] = 1'b0;
      t0 = cyc;
      chk($sformatf("uir_ir_in%0d", k), {vs_uir_a[k], ir_in_a[k]}, {1'b1, ir});
      n = 0;
      while (rsp_valid_a[k] !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("rsp_timeout%0d", k), (n < 2000), 1);
      lat = cyc - t0;
      chk($sformatf("sdr_rises%0d", k), sdr_rises[k] - s0, W);
   endtask

   initial begin
      int lat, r0;
      for (int k = 0; k < 2; k++) begin
         cmd_valid_a[k] = 1'b0; cmd_ir_a[k] = 2'b00; cmd_data_a[k] = '0;
         rsp_ready_a[k] = 1'b0; preload_val[k] = '0; slave_sr[k] = '0;
      end
      rsp_ready_a[1] = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready_a[0], 1'b1);
      chk("rst_outs", {rsp_valid_a[0], vs_tck_a[0], vs_uir_a[0], vs_sdr_a[0], ir_in_a[0]}, '0);
      reset = 1'b0;
      @(negedge clk);

      // Basic scan with the response held off
      do_scan(0, 2'b01, 38'h2A_A5A5_A5A5, 38'h12_3456_789A, lat);
      chk("lat_default", lat, 180);
      chk("basic_rsp_data", rsp_data_a[0], 38'h12_3456_789A);
      chk("basic_slave", slave_sr[0], 38'h2A_A5A5_A5A5);
      chk("basic_rsp_ir", rsp_ir_a[0], EXP_RSP_IR);

      // Backpressure: response held, new command offered and ignored
      r0 = tck_rises[0];
      cmd_data_a[0]  = 38'h11_1111_1111;
      cmd_ir_a[0]    = 2'b11;
      cmd_valid_a[0] = 1'b1;
      repeat (50) @(negedge clk);
      chk("bp_rsp_data", rsp_data_a[0], 38'h12_3456_789A);
      chk("bp_cmd_ready", cmd_ready_a[0], 1'b0);
      chk("bp_rsp_valid", rsp_valid_a[0], 1'b1);
      chk("bp_tck_idle", tck_rises[0] - r0, 0);
      chk("bp_ir_in", ir_in_a[0], 2'b01);
      cmd_valid_a[0] = 1'b0;
      rsp_ready_a[0] = 1'b1;
      @(negedge clk);
      chk("bp_release", {cmd_ready_a[0], rsp_valid_a[0]}, 2'b10);

      // Reset in the middle of SDR
      preload_val[0] = 38'h0A_BCDE_F012;
      cmd_ir_a[0]    = 2'b10;
      cmd_data_a[0]  = 38'h05_5555_0000;
      cmd_valid_a[0] = 1'b1;
      @(negedge clk);
      cmd_valid_a[0] = 1'b0;
      repeat (59) @(negedge clk);
      chk("mid_in_sdr", vs_sdr_a[0], 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_cmd_ready", cmd_ready_a[0], 1'b1);
      chk("mid_rst_outs", {vs_tck_a[0], vs_uir_a[0], vs_cdr_a[0], vs_sdr_a[0], vs_udr_a[0],
                           vs_rti_a[0], vs_tdi_a[0], ir_in_a[0], rsp_valid_a[0]}, '0);
      chk("mid_rst_rsp_data", rsp_data_a[0], '0);
      repeat (5) @(negedge clk);
      chk("mid_no_rsp", rsp_valid_a[0], 1'b0);
      do_scan(0, 2'b10, 38'h3F_FFFF_FFFF, 38'h00_0F0F_1234, lat);
      chk("lat_after_rst", lat, 180);
      chk("after_rst_data", rsp_data_a[0], 38'h00_0F0F_1234);
      chk("after_rst_slave", slave_sr[0], 38'h3F_FFFF_FFFF);
      repeat (3) @(negedge clk);

      // Fast instance: TCK every clk, one RTI period
      r0 = tck_rises[1];
      do_scan(1, 2'b11, 38'h01_2345_6789, 38'h15_5555_AAAA, lat);
      chk("lat_fast", lat, 84);
      chk("fast_rsp_data", rsp_data_a[1], 38'h15_5555_AAAA);
      chk("fast_slave", slave_sr[1], 38'h01_2345_6789);
      chk("fast_tck_rises", tck_rises[1] - r0, 42);
      chk("fast_rsp_ir", rsp_ir_a[1], EXP_RSP_IR);
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/nios2_debug_jtag_scan_master.md
Name: nios2_debug_jtag_scan_master

Overview:
- Single-clock initiator that drives the virtual-JTAG side of the Nios II debug slave.
- It replaces the `sld_virtual_jtag_basic` hub for simulation and for on-chip self-test/boot-load paths.
- Accepts a command {IR, 38-bit data}, generates the TCK-divided UIR/CDR/SDR/UDR/RTI sequence, and shifts data in on TDI while capturing TDO.
- Returns the captured scan word to the requester over a valid/ready response channel.

Parameters:
- SR_WIDTH, 38: scan register length in bits; equals jdo/sr width.
- TCK_DIV, 2: clk cycles per TCK half-period; must be >= 1.
- RTI_CYCLES, 4: TCK periods held in run-test-idle after UDR, so the debug slave's sysclk take_action strobes can fire; must be >= 1.

Ports:
- clk  in  1  system clock; also the clock the debug slave's sysclk half runs on.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_ir  in  2  virtual IR value to load (00..11).
- cmd_data  in  SR_WIDTH  word to shift in, LSB first.
- rsp_valid  out  1  captured word available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  SR_WIDTH  word shifted out of the slave, LSB first received.
- rsp_ir  out  2  captured ir_out (see optional feature).
- vs_tck  out  1  generated TCK.
- vs_tdi  out  1  serial data to slave.
- vs_tdo  in  1  serial data from slave.
- ir_in  out  2  virtual IR to slave.
- ir_out  in  2  slave IR status.
- vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti  out  1 each  virtual JTAG state indicators.

Behaviour:
- Reset (synchronous, active-high) forces the following values in the same clk edge:
  - All outputs to 0, except cmd_ready=1.
  - State IDLE; TCK divider to 0.
  - Any in-flight scan or pending response is discarded.
- TCK generation:
  - Divider counts 0..TCK_DIV-1 while not IDLE; on wrap, vs_tck toggles.
  - TCK starts low on leaving IDLE; one TCK period = 2*TCK_DIV clk cycles.
- Change and sample points:
  - State indicators, ir_in and vs_tdi change only on the clk edge where vs_tck goes 1->0, or on the entry edge from IDLE.
  - vs_tdo and ir_out are sampled on the clk edge where vs_tck goes 1->0, i.e. at the end of the high phase.
- State machine (each state lasts whole TCK periods):
  - IDLE: cmd_ready=1 iff rsp_valid=0. On accept, latch cmd_ir to ir_in, load shreg=cmd_data, go to UIR.
  - UIR: vs_uir=1 for 1 period, then CDR.
  - CDR: vs_cdr=1 for 1 period. vs_tdi=shreg[0] is presented at exit. Then SDR.
  - SDR: vs_sdr=1 for exactly SR_WIDTH periods. At each falling edge: shreg <= {vs_tdo, shreg[SR_WIDTH-1:1]} and vs_tdi <= new shreg[0]. Bit counter counts 0..SR_WIDTH-1; exit on the terminal count. Then UDR.
  - UDR: vs_udr=1 for 1 period, vs_tdi=0, then RTI.
  - RTI: vs_rti=1 for RTI_CYCLES periods, then DONE.
  - DONE: one clk cycle. rsp_data <= shreg, rsp_valid <= 1, tck stays low, go to IDLE.
- Latency:
  - rsp_valid rises (3+SR_WIDTH+RTI_CYCLES)*2*TCK_DIV clk cycles after the accept cycle.
  - Defaults: 180 cycles.
- Response hold:
  - rsp_valid holds, with rsp_data/rsp_ir stable, until rsp_ready.
  - A response is cleared on the rsp_valid && rsp_ready edge; cmd_ready rises in the next cycle.
- cmd_valid while busy is ignored; there is no queueing.
- ir_in holds the last command's IR in IDLE; it returns to 0 only on reset.
- Exactly SR_WIDTH rising TCK edges occur with vs_sdr=1 per command; no extra TCK edges occur in IDLE.

Optional Feature:
- Macro: `NIOS2_DBG_SCAN_IR_CAPTURE_EN`.
- Defined: ir_out is sampled at the final falling TCK edge of UIR and returned as rsp_ir with the response.
- Undefined: rsp_ir is tied to 2'b00 and no ir_out register exists.

Test Plan:
- Reset check: assert reset 3 cycles -> vs_* = 0, ir_in = 0, rsp_valid = 0, cmd_ready = 1, vs_tck static.
- Basic scan: bench shift-register model preloaded with 38'h12_3456_789A; send cmd_ir=2'b01, cmd_data=38'h2A_A5A5_A5A5 ->
  - one vs_uir period with ir_in=01;
  - 38 TCK rising edges under vs_sdr;
  - model holds 38'h2A_A5A5_A5A5;
  - rsp_data=38'h12_3456_789A;
  - rsp_valid exactly 180 cycles after accept.
- Backpressure: hold rsp_ready=0 for 50 cycles after rsp_valid -> rsp_data stable, cmd_ready=0, a new cmd_valid is not accepted, vs_tck idle. Release rsp_ready -> cmd_ready=1 the next cycle.
- Reset mid-scan: assert reset at cycle 60 after accept (inside SDR) -> all outputs 0 next cycle, no rsp_valid. A following cmd_data=38'h3F_FFFF_FFFF completes correctly.
- TCK_DIV=1, RTI_CYCLES=1 -> vs_tck toggles every clk during the scan; latency (3+38+1)*2 = 84 cycles; data correct.
- Optional feature: model drives ir_out=2'b10 during UIR -> rsp_ir=2'b10 with the macro defined, 2'b00 without it.
